// File: rtl/hex_rate_controller.sv
// rtl/hex_rate_controller.sv - rate divider and sequencer FSM driving the HEX0 counter enable tick
module hex_rate_controller #(
    parameter int          WIDTH   = 28,
    parameter int unsigned PERIOD1 = 49999999,
    parameter int unsigned PERIOD2 = 99999999,
    parameter int unsigned PERIOD3 = 199999999
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_sel_valid,
    output logic             o_sel_ready,
    input  logic [1:0]       i_sel_speed,
    input  logic             i_run,
    input  logic             i_step,
    output logic             o_tick,
    output logic [WIDTH-1:0] o_count,
    output logic [1:0]       o_state,
    output logic [1:0]       o_speed
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_COUNT = 2'b10
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [1:0]       r_speed;
    logic             r_tick;
    logic             w_accept;

    // Reload value for a speed code; speed 0 reloads 0 so it ticks every cycle.
    function automatic logic [WIDTH-1:0] period(input logic [1:0] s);
        case (s)
            2'd1:    period = WIDTH'(PERIOD1);
            2'd2:    period = WIDTH'(PERIOD2);
            2'd3:    period = WIDTH'(PERIOD3);
            default: period = '0;
        endcase
    endfunction

    // A speed change is only refused during the single LOAD cycle.
    always_comb begin
        o_sel_ready = (r_state != ST_LOAD);
        w_accept    = i_sel_valid && o_sel_ready;
    end

    // Sequencer: speed changes restart the period via LOAD, run pauses/resumes, step pulses from IDLE.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_speed <= 2'd0;
            r_tick  <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_speed <= i_sel_speed;
                        r_state <= ST_LOAD;
                    end else if (i_run) begin
                        // count is held so a paused divider resumes mid-period
                        r_state <= ST_COUNT;
                    end else if (i_step) begin
                        r_tick <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    r_count <= period(r_speed);
                    r_state <= i_run ? ST_COUNT : ST_IDLE;
                end
                ST_COUNT: begin
                    if (w_accept) begin
                        r_speed <= i_sel_speed;
                        r_state <= ST_LOAD;
                    end else if (!i_run) begin
                        r_state <= ST_IDLE;
                    end else if (r_count == '0) begin
                        // reload instead of wrapping; tick spacing is period+1
                        r_tick  <= 1'b1;
                        r_count <= period(r_speed);
                    end else begin
                        r_count <= r_count - WIDTH'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_tick  = r_tick;
    assign o_count = r_count;
    assign o_state = r_state;
    assign o_speed = r_speed;

endmodule
